// File: rtl/decode_stage.sv
// LoongArch32 decode stage: combinational decode feeding a single registered
// bundle, with a load-use interlock and valid/ready handshakes on both sides.
module decode_stage #(
    parameter int unsigned RF_W      = 10,
    parameter int unsigned STALL_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RF_W-1:0] rf_addr1,
    output logic [RF_W-1:0] rf_addr2,
    output logic [RF_W-1:0] rf_rd,
    output logic            rf_we,
    output logic            mem_we,
    output logic            wb_sel,
    output logic [31:0]     imm,
    output logic [11:0]     alu_op,
    output logic [1:0]      alu_src1_sel,
    output logic [1:0]      alu_src2_sel,
    output logic [1:0]      br_type,
    output logic            illegal
);
    typedef enum logic [3:0] {
        OP_ILL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST,
        OP_LU12I, OP_B, OP_BEQ, OP_BNE
    } op_e;

    typedef struct packed {
        logic [4:0]  addr1;
        logic [4:0]  addr2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        mem_we;
        logic        wb_sel;
        logic [31:0] imm;
        logic [11:0] alu_op;
        logic [1:0]  src1_sel;
        logic [1:0]  src2_sel;
        logic [1:0]  br_type;
        logic        illegal;
    } bundle_t;

    // The hazard cycle is itself the first blocked cycle, so the counter
    // only covers the remaining STALL_CYC-1 cycles.
    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYC - 1);

    op_e        op;
    bundle_t    bundle_d, bundle_q;
    logic       out_valid_q, last_ld_q;
    logic [4:0] ld_rd_q;
    logic [2:0] stall_q;
    logic       hazard, xfer, backpressure;

    always_comb begin
        if      (inst[31:15] == 17'h00020) op = OP_ADD;
        else if (inst[31:15] == 17'h00022) op = OP_SUB;
        else if (inst[31:15] == 17'h00029) op = OP_AND;
        else if (inst[31:15] == 17'h0002A) op = OP_OR;
        else if (inst[31:22] == 10'h00A)   op = OP_ADDI;
        else if (inst[31:22] == 10'h0A2)   op = OP_LD;
        else if (inst[31:22] == 10'h0A6)   op = OP_ST;
        else if (inst[31:25] == 7'h0A)     op = OP_LU12I;
        else if (inst[31:26] == 6'h14)     op = OP_B;
        else if (inst[31:26] == 6'h16)     op = OP_BEQ;
        else if (inst[31:26] == 6'h17)     op = OP_BNE;
        else                               op = OP_ILL;
    end

    always_comb begin
        bundle_d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                bundle_d.addr1    = inst[9:5];
                bundle_d.addr2    = inst[14:10];
                bundle_d.rd       = inst[4:0];
                bundle_d.rf_we    = 1'b1;
                bundle_d.wb_sel   = 1'b1;
                bundle_d.src1_sel = 2'b01;
                bundle_d.src2_sel = 2'b01;
                bundle_d.alu_op[0] = (op == OP_ADD);
                bundle_d.alu_op[1] = (op == OP_SUB);
                bundle_d.alu_op[2] = (op == OP_AND);
                bundle_d.alu_op[3] = (op == OP_OR);
            end
            OP_ADDI, OP_LD, OP_ST: begin
                bundle_d.addr1     = inst[9:5];
                bundle_d.imm       = {{20{inst[21]}}, inst[21:10]};
                bundle_d.alu_op[0] = 1'b1;
                bundle_d.src1_sel  = 2'b01;
                if (op == OP_ST) begin
                    bundle_d.addr2  = inst[4:0];
                    bundle_d.mem_we = 1'b1;
                end else begin
                    bundle_d.rd     = inst[4:0];
                    bundle_d.rf_we  = 1'b1;
                    bundle_d.wb_sel = (op == OP_ADDI);
                end
            end
            OP_LU12I: begin
                bundle_d.rd        = inst[4:0];
                bundle_d.imm       = {inst[24:5], 12'h000};
                bundle_d.rf_we     = 1'b1;
                bundle_d.wb_sel    = 1'b1;
                bundle_d.alu_op[0] = 1'b1;
                bundle_d.src1_sel  = 2'b11;
            end
            OP_BEQ, OP_BNE: begin
                bundle_d.addr1     = inst[9:5];
                bundle_d.addr2     = inst[4:0];
                bundle_d.imm       = {{14{inst[25]}}, inst[25:10], 2'b00};
                bundle_d.alu_op[1] = 1'b1;
                bundle_d.src1_sel  = 2'b01;
                bundle_d.src2_sel  = 2'b01;
                bundle_d.br_type   = (op == OP_BEQ) ? 2'b10 : 2'b01;
            end
            OP_B: begin
                bundle_d.imm     = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
                bundle_d.br_type = 2'b11;
            end
            default: bundle_d.illegal = 1'b1;
        endcase
    end

    // Unused source fields decode to 0 and ld_rd_q is never 0, so r0 never matches.
    assign hazard = in_valid && last_ld_q && (stall_q == 3'd0) &&
                    ((bundle_d.addr1 == ld_rd_q) || (bundle_d.addr2 == ld_rd_q));
    assign backpressure = out_valid_q && !out_ready;
    assign in_ready = !flush && (stall_q == 3'd0) && !hazard && !backpressure;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            last_ld_q   <= 1'b0;
            ld_rd_q     <= '0;
            stall_q     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            last_ld_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            if (xfer) begin
                bundle_q    <= bundle_d;
                out_valid_q <= 1'b1;
                last_ld_q   <= (op == OP_LD) && (inst[4:0] != 5'd0);
                ld_rd_q     <= inst[4:0];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (hazard) begin
                stall_q   <= STALL_LOAD;
                last_ld_q <= 1'b0;
            end else if ((stall_q != 3'd0) && !backpressure) begin
                stall_q <= stall_q - 3'd1;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign rf_addr1     = RF_W'(bundle_q.addr1);
    assign rf_addr2     = RF_W'(bundle_q.addr2);
    assign rf_rd        = RF_W'(bundle_q.rd);
    assign rf_we        = bundle_q.rf_we;
    assign mem_we       = bundle_q.mem_we;
    assign wb_sel       = bundle_q.wb_sel;
    assign imm          = bundle_q.imm;
    assign alu_op       = bundle_q.alu_op;
    assign alu_src1_sel = bundle_q.src1_sel;
    assign alu_src2_sel = bundle_q.src2_sel;
    assign br_type      = bundle_q.br_type;
    assign illegal      = bundle_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, directed handshake/stall/reset sequences,
// then random traffic against a cycle-level reference model for two stall lengths.
module tb_decode_stage;
    typedef struct packed {
        logic [9:0]  a1;
        logic [9:0]  a2;
        logic [9:0]  rd;
        logic        we;
        logic        mem;
        logic        wb;
        logic [31:0] imm;
        logic [11:0] alu;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [1:0]  br;
        logic        ill;
    } bnd_t;

    typedef struct {
        logic [31:0] inst;
        bnd_t        exp;
    } vec_t;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_LD, K_ST, K_LU,
                      K_B, K_BEQ, K_BNE, K_ILL} kind_e;

    logic clk = 1'b0;
    logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] inst = '0;
    always #5 clk = ~clk;

    logic        rdy_w [2];
    logic        ov_w  [2];
    bnd_t        got   [2];
    logic [9:0]  a1_w [2], a2_w [2], rd_w [2];
    logic        we_w [2], mem_w [2], wb_w [2], ill_w [2];
    logic [31:0] imm_w [2];
    logic [11:0] alu_w [2];
    logic [1:0]  s1_w [2], s2_w [2], br_w [2];

    decode_stage #(.RF_W(10), .STALL_CYC(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .inst(inst), .out_valid(ov_w[0]), .out_ready(out_ready),
        .rf_addr1(a1_w[0]), .rf_addr2(a2_w[0]), .rf_rd(rd_w[0]),
        .rf_we(we_w[0]), .mem_we(mem_w[0]), .wb_sel(wb_w[0]), .imm(imm_w[0]),
        .alu_op(alu_w[0]), .alu_src1_sel(s1_w[0]), .alu_src2_sel(s2_w[0]),
        .br_type(br_w[0]), .illegal(ill_w[0]));

    decode_stage #(.RF_W(10), .STALL_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .inst(inst), .out_valid(ov_w[1]), .out_ready(out_ready),
        .rf_addr1(a1_w[1]), .rf_addr2(a2_w[1]), .rf_rd(rd_w[1]),
        .rf_we(we_w[1]), .mem_we(mem_w[1]), .wb_sel(wb_w[1]), .imm(imm_w[1]),
        .alu_op(alu_w[1]), .alu_src1_sel(s1_w[1]), .alu_src2_sel(s2_w[1]),
        .br_type(br_w[1]), .illegal(ill_w[1]));

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign got[g] = {a1_w[g], a2_w[g], rd_w[g], we_w[g], mem_w[g], wb_w[g], imm_w[g],
                         alu_w[g], s1_w[g], s2_w[g], br_w[g], ill_w[g]};
    end

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
        checks++;
        if (g !== e) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bnd_t mk(int a1, int a2, int rd, bit we, bit mem, bit wb,
                                logic [31:0] im, logic [11:0] alu, logic [1:0] s1,
                                logic [1:0] s2, logic [1:0] br, bit ill);
        bnd_t b;
        b.a1 = 10'(a1); b.a2 = 10'(a2); b.rd = 10'(rd);
        b.we = we; b.mem = mem; b.wb = wb; b.imm = im; b.alu = alu;
        b.s1 = s1; b.s2 = s2; b.br = br; b.ill = ill;
        return b;
    endfunction

    function automatic kind_e classify(logic [31:0] w);
        if (w[31:15] == 17'h00020) return K_ADD;
        if (w[31:15] == 17'h00022) return K_SUB;
        if (w[31:15] == 17'h00029) return K_AND;
        if (w[31:15] == 17'h0002A) return K_OR;
        if (w[31:22] == 10'h00A)   return K_ADDI;
        if (w[31:22] == 10'h0A2)   return K_LD;
        if (w[31:22] == 10'h0A6)   return K_ST;
        if (w[31:25] == 7'h0A)     return K_LU;
        if (w[31:26] == 6'h14)     return K_B;
        if (w[31:26] == 6'h16)     return K_BEQ;
        if (w[31:26] == 6'h17)     return K_BNE;
        return K_ILL;
    endfunction

    function automatic bnd_t ref_dec(logic [31:0] w);
        bnd_t  b = '0;
        kind_e k = classify(w);
        int    s;
        case (k)
            K_ADD, K_SUB, K_AND, K_OR: begin
                b.a1 = 10'(w[9:5]); b.a2 = 10'(w[14:10]); b.rd = 10'(w[4:0]);
                b.we = 1; b.wb = 1; b.s1 = 2'b01; b.s2 = 2'b01;
                b.alu = 12'(1 << int'(k));
            end
            K_ADDI, K_LD, K_ST: begin
                s = int'($signed(w[21:10]));
                b.imm = 32'(s); b.alu = 12'd1; b.s1 = 2'b01;
                b.a1 = 10'(w[9:5]);
                if (k == K_ST) begin b.a2 = 10'(w[4:0]); b.mem = 1; end
                else begin b.rd = 10'(w[4:0]); b.we = 1; b.wb = (k == K_ADDI); end
            end
            K_LU: begin
                b.rd = 10'(w[4:0]); b.imm = {w[24:5], 12'h000};
                b.we = 1; b.wb = 1; b.alu = 12'd1; b.s1 = 2'b11;
            end
            K_BEQ, K_BNE: begin
                s = int'($signed(w[25:10])) * 4;
                b.imm = 32'(s); b.a1 = 10'(w[9:5]); b.a2 = 10'(w[4:0]);
                b.alu = 12'd2; b.s1 = 2'b01; b.s2 = 2'b01;
                b.br = (k == K_BEQ) ? 2'b10 : 2'b01;
            end
            K_B: begin
                s = int'({w[9:0], w[25:10]});
                if (w[9]) s -= (1 << 26);
                b.imm = 32'(s * 4); b.br = 2'b11;
            end
            default: b.ill = 1;
        endcase
        return b;
    endfunction

    function automatic bit reads_reg(logic [31:0] w, logic [4:0] r);
        kind_e k = classify(w);
        bit    rs1_used = k inside {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_LD, K_ST, K_BEQ, K_BNE};
        if (r == 5'd0) return 0;
        if (rs1_used && w[9:5] == r) return 1;
        if (k inside {K_ADD, K_SUB, K_AND, K_OR} && w[14:10] == r) return 1;
        if (k inside {K_ST, K_BEQ, K_BNE} && w[4:0] == r) return 1;
        return 0;
    endfunction

    // Reference state per instance: held bundle, pending load, remaining blocked cycles.
    int          stl [2] = '{1, 3};
    logic        mvalid [2];
    bnd_t        mb [2];
    logic        mlast [2];
    logic [4:0]  mld [2];
    int          mstall [2];

    function automatic bit m_haz(int k);
        return in_valid && mlast[k] && mstall[k] == 0 && reads_reg(inst, mld[k]);
    endfunction

    function automatic bit m_rdy(int k);
        return !flush && mstall[k] == 0 && !m_haz(k) && (!mvalid[k] || out_ready);
    endfunction

    task automatic m_step(input int k);
        bit h = m_haz(k), r = m_rdy(k), bp = mvalid[k] && !out_ready;
        if (flush) begin
            mvalid[k] = 0; mstall[k] = 0; mlast[k] = 0;
        end else if (h) begin
            mstall[k] = stl[k] - 1; mlast[k] = 0;
            if (out_ready) mvalid[k] = 0;
        end else begin
            if (in_valid && r) begin
                mb[k] = ref_dec(inst); mvalid[k] = 1;
                mlast[k] = classify(inst) == K_LD && inst[4:0] != 5'd0;
                mld[k] = inst[4:0];
            end else if (out_ready) begin
                mvalid[k] = 0;
            end
            if (mstall[k] > 0 && !bp) mstall[k]--;
        end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0] ra = 5'($urandom_range(0, 3)), rb = 5'($urandom_range(0, 3)),
                    rc = 5'($urandom_range(0, 3));
        logic [31:0] rnd = $urandom;
        case ($urandom_range(0, 13))
            0: return {17'h00020, rb, ra, rc};
            1: return {17'h00022, rb, ra, rc};
            2: return {17'h00029, rb, ra, rc};
            3: return {17'h0002A, rb, ra, rc};
            4: return {10'h00A, rnd[11:0], ra, rc};
            5, 6: return {10'h0A2, rnd[11:0], ra, rc};
            7: return {10'h0A6, rnd[11:0], ra, rc};
            8: return {7'h0A, rnd[19:0], rc};
            9: return {6'h14, rnd[25:0]};
            10: return {6'h16, rnd[15:0], ra, rc};
            11: return {6'h17, rnd[15:0], ra, rc};
            default: return rnd;
        endcase
    endfunction

    localparam logic [31:0] LD_W   = 32'h28802024;
    localparam logic [31:0] ADD1_W = 32'h00100823;
    localparam logic [31:0] ADDD_W = 32'h00100885;

    vec_t vt [14];
    bnd_t add_dep;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vt[0]  = '{ADD1_W,        mk(1, 2, 3, 1, 0, 1, 32'h0, 12'h001, 2'b01, 2'b01, 2'b00, 0)};
        vt[1]  = '{32'h001110A6, mk(5, 4, 6, 1, 0, 1, 32'h0, 12'h002, 2'b01, 2'b01, 2'b00, 0)};
        vt[2]  = '{32'h0014FC1F, mk(0, 31, 31, 1, 0, 1, 32'h0, 12'h004, 2'b01, 2'b01, 2'b00, 0)};
        vt[3]  = '{32'h00150443, mk(2, 1, 3, 1, 0, 1, 32'h0, 12'h008, 2'b01, 2'b01, 2'b00, 0)};
        vt[4]  = '{32'h02A000E8, mk(7, 0, 8, 1, 0, 1, 32'hFFFFF800, 12'h001, 2'b01, 2'b00, 2'b00, 0)};
        vt[5]  = '{LD_W,          mk(1, 0, 4, 1, 0, 0, 32'h8, 12'h001, 2'b01, 2'b00, 2'b00, 0)};
        vt[6]  = '{32'h299FFC69, mk(3, 9, 0, 0, 1, 0, 32'h7FF, 12'h001, 2'b01, 2'b00, 2'b00, 0)};
        vt[7]  = '{32'h1500002A, mk(0, 0, 10, 1, 0, 1, 32'h80001000, 12'h001, 2'b11, 2'b00, 2'b00, 0)};
        vt[8]  = '{32'h5BFFF022, mk(1, 2, 0, 0, 0, 0, 32'hFFFFFFF0, 12'h002, 2'b01, 2'b01, 2'b10, 0)};
        vt[9]  = '{32'h5C001064, mk(3, 4, 0, 0, 0, 0, 32'h10, 12'h002, 2'b01, 2'b01, 2'b01, 0)};
        vt[10] = '{32'h53FFFFFF, mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 12'h000, 2'b00, 2'b00, 2'b11, 0)};
        vt[11] = '{32'h50000001, mk(0, 0, 0, 0, 0, 0, 32'h00040000, 12'h000, 2'b00, 2'b00, 2'b11, 0)};
        vt[12] = '{32'hFFFFFFFF, mk(0, 0, 0, 0, 0, 0, 32'h0, 12'h000, 2'b00, 2'b00, 2'b00, 1)};
        vt[13] = '{32'h00000000, mk(0, 0, 0, 0, 0, 0, 32'h0, 12'h000, 2'b00, 2'b00, 2'b00, 1)};
        add_dep = mk(4, 2, 5, 1, 0, 1, 32'h0, 12'h001, 2'b01, 2'b01, 2'b00, 0);

        // Reset state
        tick();
        chk("rst_ov", ov_w[0], 0);
        chk("rst_bundle", got[0], 0);
        rst = 0;
        #1 chk("rst_rdy", rdy_w[0], 1);

        // Vector table, flushing between entries so no entry interlocks on the previous one
        for (int i = 0; i < 14; i++) begin
            in_valid = 1; inst = vt[i].inst; flush = 0;
            #1 chk($sformatf("vec%0d_rdy", i), rdy_w[0], 1);
            tick();
            in_valid = 0; flush = 1;
            #1 chk($sformatf("vec%0d_ov", i), ov_w[0], 1);
            chk($sformatf("vec%0d_bundle", i), got[0], vt[i].exp);
            tick();
            flush = 0;
        end

        // Load-use with STALL_CYC=1
        in_valid = 1; inst = LD_W;
        #1 chk("lu_ld_rdy", rdy_w[0], 1);
        tick();
        inst = ADDD_W;
        #1 chk("lu_block", rdy_w[0], 0);
        chk("lu_ld_bundle", got[0], vt[5].exp);
        tick();
        #1 chk("lu_bubble", ov_w[0], 0);
        chk("lu_resume", rdy_w[0], 1);
        tick();
        in_valid = 0;
        #1 chk("lu_add_ov", ov_w[0], 1);
        chk("lu_add_bundle", got[0], add_dep);

        // Back-pressure hold then release
        out_ready = 0; in_valid = 1; inst = ADD1_W;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("bp%0d_rdy", c), rdy_w[0], 0);
            chk($sformatf("bp%0d_hold", c), {ov_w[0], got[0]}, {1'b1, add_dep});
            tick();
        end
        out_ready = 1;
        #1 chk("bp_release_rdy", rdy_w[0], 1);
        tick();
        in_valid = 0;
        #1 chk("bp_next_bundle", {ov_w[0], got[0]}, {1'b1, vt[0].exp});

        // Asynchronous reset while holding a bundle
        out_ready = 0; in_valid = 1;
        #2 rst = 1;
        #1 chk("arst_ov", ov_w[0], 0);
        chk("arst_bundle", got[0], 0);
        chk("arst_ov3", ov_w[1], 0);
        tick();
        rst = 0; in_valid = 0; out_ready = 1;
        #1 chk("arst_rdy", rdy_w[0], 1);
        tick();
        chk("arst_nostale", ov_w[0], 0);

        // Load-use gap with STALL_CYC=3
        in_valid = 1; inst = LD_W;
        #1 tick();
        inst = ADDD_W;
        #1 n = 0;
        while (!rdy_w[1] && n < 20) begin
            n++;
            tick();
        end
        chk("lu3_gap", n, 3);
        tick();
        in_valid = 0;
        #1 chk("lu3_add", {ov_w[1], got[1]}, {1'b1, add_dep});

        // Flush mid-stall on the STALL_CYC=3 instance
        in_valid = 1; inst = LD_W;
        #1 tick();
        inst = ADDD_W;
        #1 chk("fl_haz", rdy_w[1], 0);
        tick();
        flush = 1;
        #1 chk("fl_rdy", rdy_w[1], 0);
        tick();
        flush = 0;
        #1 chk("fl_nobubble", rdy_w[1], 1);
        chk("fl_ov", ov_w[1], 0);
        tick();
        in_valid = 0;
        #1 chk("fl_add", {ov_w[1], got[1]}, {1'b1, add_dep});

        // Random traffic against the reference model
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            mvalid[k] = 0; mb[k] = '0; mlast[k] = 0; mld[k] = '0; mstall[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            inst      = gen_inst();
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rnd%0d_c%0d", k, c), {rdy_w[k], ov_w[k], got[k]},
                    {m_rdy(k), mvalid[k], mb[k]});
                m_step(k);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
